// File: rtl/hist_read_arbiter_pkg.sv
// Purpose: shared widths and FSM state encoding for the histogram read-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hist_read_arbiter_pkg;

    localparam int HIST_ADDR_W = 10;
    localparam int HIST_DATA_W = 16;
    localparam int HIST_RD_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/hist_read_arbiter_skid_fifo.sv
// Purpose: small synchronous show-ahead FIFO for bulk words, exposing its fill count.
// Latency: a word written at the end of cycle c is presented on rd_dat in cycle c+1.
// Backpressure: holds head while rd_rdy is low; the writer must never write when full.
module hist_skid_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [W-1:0]     wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [W-1:0]     rd_dat,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    // Pointer/count update and storage write; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        pop      = rd_rdy & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_vld) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_vld) - CNT_W'(pop);
    end

    // Control state; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset: entries are only read when counted as valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_vld = (count_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/hist_read_arbiter.sv
// Purpose: shares histogram BRAM port B between the video renderer and a blanking-only bulk reader.
// Latency: renderer sees raw BRAM latency; bulk word issued in cycle c is valid on sv_data in c+RD_LAT+1.
// Backpressure: credit check (fifo_count + inflight < FIFO_DEPTH) stalls issue; FIFO never overflows.
module hist_read_arbiter
    import hist_read_arbiter_pkg::*;
#(
    parameter int ADDR_W     = HIST_ADDR_W,
    parameter int DATA_W     = HIST_DATA_W,
    parameter int RD_LAT     = HIST_RD_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blank,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    input  logic              sv_req,
    input  logic [ADDR_W-1:0] sv_base,
    input  logic [ADDR_W:0]   sv_len,
    output logic [DATA_W-1:0] sv_data,
    output logic              sv_valid,
    input  logic              sv_ready,
    output logic              sv_busy,
    output logic              sv_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(RD_LAT + 1);
    localparam int OCC_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [RD_LAT-1:0] tag_q, tag_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [IF_W-1:0]   inflight;
    logic [OCC_W-1:0]  occupancy;
    logic              credit_ok;
    logic              issue;
    logic              tag_exit;
    logic              pop;

    // Credit accounting: every issued read reserves a FIFO slot until it lands.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IF_W'(tag_q[i]);
        end
        occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
        credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));
        issue     = (state_q == ST_FETCH) & blank & credit_ok;
        tag_exit  = tag_q[RD_LAT-1];
        pop       = sv_valid & sv_ready;
    end

    // Tag pipe mirrors the BRAM read latency; its exiting bit writes bram_dout into the FIFO.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Next-state logic. A zero-length request goes through DRAIN so sv_done lands two cycles
    // after the request; in a real burst DRAIN always exits on the final pop, since a tag is
    // still in flight on entry and the FIFO cannot be empty until the last word is accepted.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sv_req) begin
                    addr_d   = sv_base;
                    remain_d = sv_len;
                    state_d  = (sv_len == '0) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W + 1)'(1);
                    if (remain_q == (ADDR_W + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any burst and clears in-flight tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            tag_q    <= tag_d;
        end
    end

    hist_skid_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (tag_exit),
        .wr_dat (bram_dout),
        .rd_vld (sv_valid),
        .rd_rdy (sv_ready),
        .rd_dat (sv_data),
        .count  (fifo_count)
    );

    // The renderer owns the port during active video and never sees added latency.
    assign bram_addr = blank ? addr_q : vid_addr;
    assign vid_data  = bram_dout;
    assign sv_busy   = (state_q != ST_IDLE);
    assign sv_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_hist_read_arbiter.sv
`timescale 1ns/1ps
module tb_hist_read_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          blank;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic          sv_req;
    logic [AW-1:0] sv_base;
    logic [AW:0]   sv_len;
    logic [DW-1:0] sv_data;
    logic          sv_valid;
    logic          sv_ready;
    logic          sv_busy;
    logic          sv_done;

    always #5 clk = ~clk;

    hist_read_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .blank     (blank),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .sv_req    (sv_req),
        .sv_base   (sv_base),
        .sv_len    (sv_len),
        .sv_data   (sv_data),
        .sv_valid  (sv_valid),
        .sv_ready  (sv_ready),
        .sv_busy   (sv_busy),
        .sv_done   (sv_done)
    );

    // Histogram contents: low 10 bits carry the address, so every word is distinct.
    function automatic logic [DW-1:0] mem_fn(input int a);
        logic [9:0] av;
        av = 10'(a);
        return {av[5:0], av} ^ 16'h5A3C;
    endfunction

    // BRAM model with two cycles of read latency.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] dly1;
    initial for (int i = 0; i < 1024; i++) mem[i] = mem_fn(i);
    always @(posedge clk) begin
        dly1      <= mem[bram_addr];
        bram_dout <= dly1;
    end

    typedef struct {
        int base;
        int len;
        bit bp;        // 1: sv_ready high one cycle in three
        int gap_at;    // blank drops after this many cycles past the request
        int gap_len;
        bit chk_lat;
        int exp_n;     // words expected
        int exp_last;  // address of the last word expected
    } vec_t;

    logic [DW-1:0] exp_q[$];
    int  n_vec = 0, n_err = 0, cyc = 0;
    bit  ready_mode = 0;
    int  issue_cnt = 0, pops = 0, done_cnt = 0;
    int  first_issue, first_valid, first_pop, last_pop, done_cyc, req_cyc;
    logic [DW-1:0] last_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive just after the rising edge, observe at the falling edge.
    task automatic tick();
        logic [DW-1:0] e;
        @(posedge clk);
        cyc++;
        #1;
        sv_req   = 1'b0;
        vid_addr = AW'(cyc);
        sv_ready = ready_mode ? ((cyc % 3) == 0) : 1'b1;
        @(negedge clk);
        if (!reset) begin
            if (!blank) begin
                chk("mux_vid", bram_addr, vid_addr);
                chk("no_issue_active", dut.issue, 0);
            end
            chk("vid_data", vid_data, bram_dout);
            chk("fifo_le_depth", (dut.fifo_count <= DEPTH), 1);
            if (dut.issue) begin
                issue_cnt++;
                if (first_issue < 0) first_issue = cyc;
            end
            if (sv_valid && first_valid < 0) first_valid = cyc;
            if (sv_valid && sv_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", sv_data, 32'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", sv_data, e);
                end
                if (first_pop < 0) first_pop = cyc;
                pops++;
                last_pop  = cyc;
                last_data = sv_data;
            end
            if (sv_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_in_done", sv_busy, 1);
            end
        end
    endtask

    // Request is driven mid-cycle and sampled by the edge closing cycle req_cyc.
    task automatic start_req(input int base, input int len, input bit push);
        first_issue = -1; first_valid = -1; first_pop = -1;
        sv_req  = 1'b1;
        sv_base = AW'(base);
        sv_len  = (AW + 1)'(len);
        req_cyc = cyc;
        if (push) for (int i = 0; i < len; i++) exp_q.push_back(mem_fn((base + i) % 1024));
    endtask

    task automatic wait_done(input int budget, input int gap_at, input int gap_len);
        int n;
        int d0;
        bit ok;
        n = 0; d0 = done_cnt; ok = 0;
        while (n < budget) begin
            tick();
            n++;
            if (n == 1) chk("busy_t1", sv_busy, 1);
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
            if (gap_len > 0 && n == gap_at) blank = 1'b0;
            if (gap_len > 0 && n == gap_at + gap_len) blank = 1'b1;
        end
        chk("done_seen", ok, 1);
    endtask

    task automatic after_done(input int d0);
        chk("done_once", done_cnt - d0, 1);
        chk("queue_empty", exp_q.size(), 0);
        tick();
        chk("idle_busy", sv_busy, 0);
        chk("done_pulse", sv_done, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int p0, i0, d0, n;

        vecs[0] = '{base: 100,  len: 16,   bp: 0, gap_at: 0, gap_len: 0, chk_lat: 1, exp_n: 16,   exp_last: 115};
        vecs[1] = '{base: 40,   len: 32,   bp: 1, gap_at: 0, gap_len: 0, chk_lat: 0, exp_n: 32,   exp_last: 71};
        vecs[2] = '{base: 1020, len: 8,    bp: 0, gap_at: 3, gap_len: 5, chk_lat: 0, exp_n: 8,    exp_last: 3};
        vecs[3] = '{base: 5,    len: 1024, bp: 0, gap_at: 0, gap_len: 0, chk_lat: 0, exp_n: 1024, exp_last: 4};
        vecs[4] = '{base: 1023, len: 1,    bp: 1, gap_at: 0, gap_len: 0, chk_lat: 0, exp_n: 1,    exp_last: 1023};

        reset = 1'b1; blank = 1'b0; sv_req = 1'b0; sv_base = '0; sv_len = '0;
        sv_ready = 1'b1; vid_addr = '0;
        first_issue = -1; first_valid = -1; first_pop = -1;
        last_pop = 0; done_cyc = 0; req_cyc = 0; last_data = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", sv_valid, 0);
        chk("rst_busy", sv_busy, 0);
        chk("rst_done", sv_done, 0);
        chk("rst_mux", bram_addr, vid_addr);
        reset = 1'b0;
        tick();
        blank = 1'b1;
        tick();
        chk("rst_addr_reg", bram_addr, 0);

        // Active-video isolation: request parked until blanking
        blank = 1'b0;
        p0 = pops; i0 = issue_cnt; d0 = done_cnt;
        start_req(0, 8, 1);
        repeat (20) tick();
        chk("active_no_issue", issue_cnt - i0, 0);
        chk("active_no_valid", sv_valid, 0);
        blank = 1'b1;
        wait_done(200, 0, 0);
        chk("active_words", pops - p0, 8);
        chk("active_last", last_data, mem_fn(7));
        after_done(d0);

        // Zero-length request
        p0 = pops; i0 = issue_cnt; d0 = done_cnt;
        start_req(0, 0, 1);
        wait_done(20, 0, 0);
        chk("len0_done_t2", done_cyc - req_cyc, 2);
        chk("len0_no_issue", issue_cnt - i0, 0);
        chk("len0_no_word", pops - p0, 0);
        after_done(d0);

        // Second request while busy is ignored
        p0 = pops; d0 = done_cnt;
        start_req(200, 16, 1);
        repeat (3) tick();
        start_req(500, 4, 0);
        wait_done(300, 0, 0);
        chk("ign_words", pops - p0, 16);
        chk("ign_last", last_data, mem_fn(215));
        after_done(d0);
        repeat (20) tick();
        chk("ign_no_extra_done", done_cnt - d0, 1);
        chk("ign_no_extra_word", pops - p0, 16);

        // Reset mid-burst
        p0 = pops; d0 = done_cnt;
        start_req(300, 16, 1);
        n = 0;
        while ((pops - p0) < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("rstmid_reached5", pops - p0, 5);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("rstmid_valid", sv_valid, 0);
        chk("rstmid_busy", sv_busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_valid_after", sv_valid, 0);
        chk("rstmid_busy_after", sv_busy, 0);

        // Table of bursts
        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].bp;
            blank = 1'b1;
            tick();
            p0 = pops; i0 = issue_cnt; d0 = done_cnt;
            start_req(vecs[v].base, vecs[v].len, 1);
            wait_done(4000, vecs[v].gap_at, vecs[v].gap_len);
            chk("vec_words", pops - p0, vecs[v].exp_n);
            chk("vec_issues", issue_cnt - i0, vecs[v].exp_n);
            chk("vec_last", last_data, mem_fn(vecs[v].exp_last));
            chk("vec_done_after_pop", done_cyc - last_pop, 1);
            if (vecs[v].chk_lat) begin
                chk("lat_first_issue", first_issue - req_cyc, 1);
                chk("lat_first_valid", first_valid - first_issue, 3);
                chk("lat_back_to_back", last_pop - first_pop, vecs[v].exp_n - 1);
            end
            after_done(d0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
